// File: rtl/rng_pkg.sv
// Shared constants for the LFSR random-number stream: mode encodings, FSM
// state type, reset seed and a table of maximal-length tap masks.
package rng_pkg;

  localparam int MODE_FIB = 0;
  localparam int MODE_GAL = 1;

  // Reset seed, truncated to the generator width where it is used.
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

  typedef enum logic [0:0] {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } rng_state_e;

  // Maximal-length tap masks for a right-shifting register. Bit i of the mask
  // corresponds to term x^(WIDTH-i) of the feedback polynomial.
  function automatic logic [31:0] default_taps(input int width);
    logic [31:0] taps;
    case (width)
      4:       taps = 32'h0000_0003;
      5:       taps = 32'h0000_0005;
      6:       taps = 32'h0000_0003;
      7:       taps = 32'h0000_0003;
      8:       taps = 32'h0000_001D;
      9:       taps = 32'h0000_0011;
      10:      taps = 32'h0000_0009;
      11:      taps = 32'h0000_0005;
      12:      taps = 32'h0000_0941;
      13:      taps = 32'h0000_1601;
      14:      taps = 32'h0000_2A01;
      15:      taps = 32'h0000_0003;
      16:      taps = 32'h0000_002D;
      17:      taps = 32'h0000_0009;
      18:      taps = 32'h0000_0081;
      19:      taps = 32'h0006_2001;
      20:      taps = 32'h0000_0009;
      21:      taps = 32'h0000_0005;
      22:      taps = 32'h0000_0003;
      23:      taps = 32'h0000_0021;
      24:      taps = 32'h0000_0087;
      25:      taps = 32'h0000_0009;
      26:      taps = 32'h0310_0001;
      27:      taps = 32'h0640_0001;
      28:      taps = 32'h0000_0009;
      29:      taps = 32'h0000_0005;
      30:      taps = 32'h2500_0001;
      31:      taps = 32'h0000_0009;
      32:      taps = 32'hC000_0401;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step. Fibonacci: XOR of the tapped bits enters at
// the MSB as the register shifts right. Galois: shift right and, when the
// bit shifted out is 1, XOR the tap mask into the shifted value.
module lfsr_step
  import rng_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               MODE  = MODE_FIB,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  generate
    if (MODE == MODE_GAL) begin : g_galois
      // Galois step: conditional tap-mask XOR driven by the outgoing bit.
      always_comb begin
        nxt = {1'b0, cur[WIDTH-1:1]} ^ ({WIDTH{cur[0]}} & TAPS);
      end
    end else begin : g_fibonacci
      // Fibonacci step: parity of tapped bits becomes the new MSB.
      always_comb begin
        nxt = {^(cur & TAPS), cur[WIDTH-1:1]};
      end
    end
  endgenerate

endmodule

// File: rtl/lfsr_rng_stream.sv
// LFSR random-number source with a valid/ready output stream. The LFSR
// advances LEAP steps per produced sample, optionally discards WARMUP
// samples after reset/reseed, and never holds the all-zero lock-up state.
module lfsr_rng_stream
  import rng_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               MODE         = MODE_FIB,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
  parameter int               LEAP         = 1,
  parameter int               WARMUP       = 0,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             seed_zero,
  output logic [31:0]      sample_cnt
);

  // With no warm-up the generator starts directly in the streaming state.
  localparam rng_state_e INIT_STATE = (WARMUP == 0) ? ST_RUN : ST_WARM;
  localparam logic [7:0] WARM_LAST  = 8'(WARMUP - 1);

  rng_state_e                 state;
  logic [WIDTH-1:0]           lfsr;
  logic [7:0]                 warm_cnt;
  logic [LEAP:0][WIDTH-1:0]   chain;
  logic [WIDTH-1:0]           stepped;
  logic [WIDTH-1:0]           lfsr_next;
  logic [WIDTH-1:0]           seed_value;
  logic                       slot_free;

  assign chain[0] = lfsr;

  // LEAP single-step stages chained combinationally.
  genvar gi;
  generate
    for (gi = 0; gi < LEAP; gi++) begin : g_leap
      lfsr_step #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .TAPS  (TAPS)
      ) u_step (
        .cur (chain[gi]),
        .nxt (chain[gi+1])
      );
    end
  endgenerate

  assign stepped = chain[LEAP];

  // Next LEAP-step state; a zero result (possible with non-maximal taps) is replaced by the default seed.
  always_comb begin
    if (stepped == '0) begin
      lfsr_next = SEED_DEFAULT;
    end else begin
      lfsr_next = stepped;
    end
  end

  // Seed to load, with the all-zero seed substituted by the default.
  always_comb begin
    if (seed == '0) begin
      seed_value = SEED_DEFAULT;
    end else begin
      seed_value = seed;
    end
  end

  // The output register may take a new sample when empty or being consumed.
  always_comb begin
    slot_free = !out_valid || out_ready;
  end

  // Generator FSM: warm-up discard, output register and reseed handling.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= INIT_STATE;
      lfsr      <= SEED_DEFAULT;
      warm_cnt  <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      seed_zero <= 1'b0;
    end else begin
      seed_zero <= 1'b0;
      if (seed_load) begin
        // Reseed wins over everything; any pending sample is dropped.
        lfsr      <= seed_value;
        warm_cnt  <= 8'd0;
        state     <= INIT_STATE;
        out_valid <= 1'b0;
        seed_zero <= (seed == '0);
      end else begin
        case (state)
          ST_WARM: begin
            out_valid <= 1'b0;
            if (en) begin
              lfsr     <= lfsr_next;
              warm_cnt <= warm_cnt + 8'd1;
              if (warm_cnt == WARM_LAST) begin
                state <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (slot_free) begin
              if (en) begin
                lfsr      <= lfsr_next;
                out_data  <= lfsr_next;
                out_valid <= 1'b1;
              end else begin
                out_valid <= 1'b0;
              end
            end
          end
          default: begin
            state     <= INIT_STATE;
            lfsr      <= SEED_DEFAULT;
            warm_cnt  <= 8'd0;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // Accepted-sample counter; wraps naturally and survives reseeding.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_cnt <= 32'd0;
    end else if (out_valid && out_ready) begin
      sample_cnt <= sample_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_lfsr_rng_stream.sv
// Testbench for lfsr_rng_stream: table-driven handshake vectors on a default
// instance, plus sequences for reset, full period, warm-up, leap and Galois.
module tb_lfsr_rng_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  // Default-parameter instance
  logic        en, seed_load, out_ready;
  logic [15:0] seed;
  logic        out_valid, seed_zero;
  logic [15:0] out_data;
  logic [31:0] sample_cnt;

  // Shared inputs for the auxiliary instances
  logic        en_x, seed_load_x, ready_x;
  logic [15:0] seed_x;
  logic        w_valid, w_zero, l_valid, l_zero, g_valid, g_zero;
  logic [15:0] w_data, l_data, g_data;
  logic [31:0] w_cnt, l_cnt, g_cnt;

  int n_vec = 0;
  int n_bad = 0;

  lfsr_rng_stream u_def (
    .clk(clk), .rstn(rstn), .en(en), .seed_load(seed_load), .seed(seed),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .seed_zero(seed_zero), .sample_cnt(sample_cnt)
  );

  lfsr_rng_stream #(.WARMUP(4)) u_warm (
    .clk(clk), .rstn(rstn), .en(en_x), .seed_load(seed_load_x), .seed(seed_x),
    .out_ready(ready_x), .out_valid(w_valid), .out_data(w_data),
    .seed_zero(w_zero), .sample_cnt(w_cnt)
  );

  lfsr_rng_stream #(.LEAP(3)) u_leap (
    .clk(clk), .rstn(rstn), .en(en_x), .seed_load(seed_load_x), .seed(seed_x),
    .out_ready(ready_x), .out_valid(l_valid), .out_data(l_data),
    .seed_zero(l_zero), .sample_cnt(l_cnt)
  );

  lfsr_rng_stream #(.MODE(1)) u_gal (
    .clk(clk), .rstn(rstn), .en(en_x), .seed_load(seed_load_x), .seed(seed_x),
    .out_ready(ready_x), .out_valid(g_valid), .out_data(g_data),
    .seed_zero(g_zero), .sample_cnt(g_cnt)
  );

  // x^16+x^14+x^13+x^11+1 : feedback = s0 ^ s2 ^ s3 ^ s5 into bit 15
  function automatic logic [15:0] fib_ref(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // Galois right shift with mask 0x002D; a zero result is replaced by 0xACE1
  function automatic logic [15:0] gal_ref(input logic [15:0] s);
    logic [15:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 16'h002D;
    if (t == 16'h0000) t = 16'hACE1;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    en          = 1'b0;
    seed_load   = 1'b0;
    out_ready   = 1'b0;
    seed        = 16'h0000;
    en_x        = 1'b0;
    seed_load_x = 1'b0;
    ready_x     = 1'b0;
    seed_x      = 16'h0000;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    logic        load;
    logic [15:0] seed;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_zero;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[22];

  initial begin
    logic [15:0] lref, gref;
    int zeros, early_wrap;

    //           en    rdy   load  seed      valid data      zero  cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h5670, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hAB38, 1'b0, 32'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hAB38, 1'b0, 32'd1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hAB38, 1'b0, 32'd1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hAB38, 1'b0, 32'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hAB38, 1'b0, 32'd1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hAB38, 1'b0, 32'd1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h559C, 1'b0, 32'd2};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'd3};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'd3};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2ACE, 1'b0, 32'd3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2ACE, 1'b0, 32'd3};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1567, 1'b0, 32'd4};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1, 32'd5};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h5670, 1'b0, 32'd5};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hAB38, 1'b0, 32'd6};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 16'h1567, 1'b0, 16'h0000, 1'b0, 32'd6};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h8AB3, 1'b0, 32'd6};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h4559, 1'b0, 32'd7};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 16'hACE1, 1'b0, 16'h0000, 1'b0, 32'd8};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'd8};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h5670, 1'b0, 32'd8};

    // Reset state
    do_reset();
    #1;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_data", {16'd0, out_data}, 32'd0);
    check("reset_zero", {31'd0, seed_zero}, 32'd0);
    check("reset_cnt", sample_cnt, 32'd0);

    // Table-driven handshake, stall, reseed and drop behaviour
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      en        = vecs[i].en;
      out_ready = vecs[i].rdy;
      seed_load = vecs[i].load;
      seed      = vecs[i].seed;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        check($sformatf("v%0d_data", i), {16'd0, out_data}, {16'd0, vecs[i].exp_data});
      check($sformatf("v%0d_zero", i), {31'd0, seed_zero}, {31'd0, vecs[i].exp_zero});
      check($sformatf("v%0d_cnt", i), sample_cnt, vecs[i].exp_cnt);
    end

    // Asynchronous reset in the middle of streaming
    @(negedge clk);
    en = 1'b1; out_ready = 1'b1; seed_load = 1'b0;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data", {16'd0, out_data}, 32'd0);
    check("midrst_cnt", sample_cnt, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_first", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h5670});

    // Full period: 65535 samples return to the seed, zero never appears
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    zeros = 0; early_wrap = 0;
    for (int k = 1; k <= 65535; k++) begin
      @(posedge clk);
      #1;
      if (out_data == 16'h0000 || out_valid !== 1'b1) zeros++;
      if (k < 65535 && out_data == 16'hACE1) early_wrap++;
    end
    check("period_zero_or_gap", zeros, 32'd0);
    check("period_early_wrap", early_wrap, 32'd0);
    check("period_last", {16'd0, out_data}, 32'h0000_ACE1);
    check("period_cnt", sample_cnt, 32'd65534);

    // Auxiliary instances: reseed 0xACE1, then stream
    do_reset();
    @(negedge clk);
    seed_load_x = 1'b1; seed_x = 16'hACE1;
    @(posedge clk);
    #1;
    check("aux_load_valid", {29'd0, w_valid, l_valid, g_valid}, 32'd0);
    check("aux_load_zero", {29'd0, w_zero, l_zero, g_zero}, 32'd0);
    @(negedge clk);
    seed_load_x = 1'b0; en_x = 1'b1; ready_x = 1'b1;
    lref = 16'hACE1;
    gref = 16'hACE1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      lref = fib_ref(fib_ref(fib_ref(lref)));
      gref = gal_ref(gref);
      check($sformatf("leap_s%0d", k), {15'd0, l_valid, l_data}, {15'd0, 1'b1, lref});
      check($sformatf("gal_s%0d", k), {15'd0, g_valid, g_data}, {15'd0, 1'b1, gref});
      check($sformatf("warm_valid_%0d", k), {31'd0, w_valid}, (k >= 5) ? 32'd1 : 32'd0);
      if (k == 5)
        check("warm_first", {16'd0, w_data}, 32'h0000_1567);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
